// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions: default word width and the packer state type.
package fp_pkg;

  localparam int FP_WIDTH = 32;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

endpackage

// File: rtl/vector_packer.sv
// Serial-to-parallel packer: accepted words fill slots 0..NUM_WORDS-1, then the vector is held until taken.
// Partial-vector flush is compiled in only when VECTOR_PACKER_FLUSH_EN is defined.
module vector_packer
  import fp_pkg::*;
#(
  parameter int WIDTH     = FP_WIDTH,
  parameter int NUM_WORDS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NUM_WORDS*WIDTH-1:0]     out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(NUM_WORDS+1)-1:0] out_count,
  input  logic                           flush
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_WORDS);

  packer_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] slot_q [NUM_WORDS];
  logic [WIDTH-1:0] slot_d [NUM_WORDS];
  logic             in_ready_q, out_valid_q;
  logic             accept_s;

`ifndef VECTOR_PACKER_FLUSH_EN
  logic unused_flush_s;
  assign unused_flush_s = flush;
`endif

  // Words are only taken while filling; in HOLD the producer keeps its word.
  assign accept_s = (state_q == FILL) && in_valid;

  // Next-state, slot write and valid-count logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    case (state_q)
      FILL: begin
        if (accept_s) begin
          slot_d[idx_q] = in_data;
        end else begin
          slot_d = slot_q;
        end
        if (accept_s && (idx_q == IDX_LAST)) begin
          state_d = HOLD;
          idx_d   = '0;
          cnt_d   = CNT_FULL;
`ifdef VECTOR_PACKER_FLUSH_EN
        end else if (flush && (accept_s || (idx_q != '0))) begin
          // A word arriving with the flush is stored first and counted.
          state_d = HOLD;
          idx_d   = '0;
          cnt_d   = CNT_W'(idx_q) + CNT_W'(accept_s);
`endif
        end else if (accept_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          idx_d   = '0;
          cnt_d   = '0;
          for (int i = 0; i < NUM_WORDS; i++) begin
            slot_d[i] = '0;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
        cnt_d   = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
          slot_d[i] = '0;
        end
      end
    endcase
  end

  // State, slot and handshake registers; reset discards any partial or held vector at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == FILL);
      out_valid_q <= (state_d == HOLD);
      for (int i = 0; i < NUM_WORDS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Slot 0 occupies the most significant word of the packed vector.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      out_data[(NUM_WORDS-i)*WIDTH-1 -: WIDTH] = slot_q[i];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_vector_packer.sv
// Bench for vector_packer: directed scenarios plus random traffic checked against a queue-based model.
`timescale 1ns/1ps
module tb_vector_packer;

  localparam int W  = 32;
  localparam int NA = 2;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0]    a_in_data;
  logic            a_in_valid, a_in_ready;
  logic [NA*W-1:0] a_out_data;
  logic            a_out_valid, a_out_ready;
  logic [1:0]      a_out_count;
  logic            a_flush;

  logic [W-1:0]    b_in_data;
  logic            b_in_valid, b_in_ready;
  logic [NB*W-1:0] b_out_data;
  logic            b_out_valid, b_out_ready;
  logic [2:0]      b_out_count;
  logic            b_flush;

  vector_packer #(.WIDTH(W), .NUM_WORDS(NA)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_count(a_out_count), .flush(a_flush)
  );

  vector_packer #(.WIDTH(W), .NUM_WORDS(NB)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_count(b_out_count), .flush(b_flush)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model for the NUM_WORDS=2 instance: the words collected so far and whether a vector is held.
  bit           m_hold;
  int           m_cnt;
  logic [W-1:0] m_q[$];

  function automatic logic [NA*W-1:0] model_vec();
    logic [NA*W-1:0] v;
    v = '0;
    for (int i = 0; i < NA; i++) begin
      if (i < m_q.size()) v[(NA-i)*W-1 -: W] = m_q[i];
    end
    return v;
  endfunction

  task automatic model_reset();
    m_hold = 1'b0;
    m_cnt  = 0;
    m_q.delete();
  endtask

  // Drive one cycle of inputs on instance A, let the edge happen, advance the model, return at the next negedge.
  task automatic cycle_a(input logic v, input logic [W-1:0] d, input logic o, input logic f);
    a_in_valid  = v;
    a_in_data   = d;
    a_out_ready = o;
    a_flush     = f;
    @(posedge clk);
    if (!m_hold) begin
      if (v) m_q.push_back(d);
      if (m_q.size() == NA) begin
        m_hold = 1'b1;
        m_cnt  = NA;
      end
`ifdef VECTOR_PACKER_FLUSH_EN
      else if (f && (m_q.size() > 0)) begin
        m_hold = 1'b1;
        m_cnt  = m_q.size();
      end
`endif
    end else if (o) begin
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1; b_flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_count !== 2'd0) begin n_err++; $display("FAIL reset_out_count: got %0d want 0", a_out_count); end
    n_cmp++; if (a_out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", a_out_data); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    cycle_a(1'b1, 32'h3F80_0000, 1'b1, 1'b0);
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 64'h3F800000_00000000) begin n_err++; $display("FAIL basic_partial: got %h want 3f80000000000000", a_out_data); end
    cycle_a(1'b1, 32'h4000_0000, 1'b1, 1'b0);
    n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", a_out_valid); end
    n_cmp++; if (a_out_data !== 64'h3F800000_40000000) begin n_err++; $display("FAIL basic_data: got %h want 3f80000040000000", a_out_data); end
    n_cmp++; if (a_out_count !== 2'd2) begin n_err++; $display("FAIL basic_count: got %0d want 2", a_out_count); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL basic_hold_ready: got %b want 0", a_in_ready); end
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0);
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL basic_after_take: got valid %b ready %b want 0/1", a_out_valid, a_in_ready); end
    n_cmp++; if (a_out_data !== '0 || a_out_count !== 2'd0) begin n_err++; $display("FAIL basic_cleared: got %h/%0d want 0/0", a_out_data, a_out_count); end
  endtask

  task automatic test_hold();
    cycle_a(1'b1, 32'h3F80_0000, 1'b0, 1'b0);
    cycle_a(1'b1, 32'h4000_0000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin n_err++; $display("FAIL hold_flags%0d: got valid %b ready %b want 1/0", k, a_out_valid, a_in_ready); end
      n_cmp++; if (a_out_data !== 64'h3F800000_40000000) begin n_err++; $display("FAIL hold_data%0d: got %h want 3f80000040000000", k, a_out_data); end
      cycle_a(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    end
    n_cmp++; if (a_out_data !== 64'h3F800000_40000000 || a_out_count !== 2'd2) begin n_err++; $display("FAIL hold_stable: got %h/%0d want 3f80000040000000/2", a_out_data, a_out_count); end
    cycle_a(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    n_cmp++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: got ready %b valid %b want 1/0", a_in_ready, a_out_valid); end
    n_cmp++; if (a_out_data !== '0) begin n_err++; $display("FAIL hold_no_store: got %h want 0", a_out_data); end
  endtask

  task automatic test_reset_mid();
    cycle_a(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    n_cmp++; if (a_out_data !== 64'h12345678_00000000) begin n_err++; $display("FAIL rstmid_partial: got %h want 1234567800000000", a_out_data); end
    a_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (a_out_data !== '0 || a_out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_discard: got %h/%b want 0/0", a_out_data, a_out_valid); end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle_a(1'b1, 32'hAAAA_AAAA, 1'b1, 1'b0);
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_spurious: got %b want 0", a_out_valid); end
    cycle_a(1'b1, 32'hBBBB_BBBB, 1'b1, 1'b0);
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 64'hAAAAAAAA_BBBBBBBB) begin n_err++; $display("FAIL rstmid_vector: got %b/%h want 1/aaaaaaaabbbbbbbb", a_out_valid, a_out_data); end
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
`ifdef VECTOR_PACKER_FLUSH_EN
    cycle_a(1'b1, 32'h4040_0000, 1'b1, 1'b0);
    cycle_a(1'b0, 32'h0, 1'b0, 1'b1);
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_count !== 2'd1) begin n_err++; $display("FAIL flush_hold: got %b/%0d want 1/1", a_out_valid, a_out_count); end
    n_cmp++; if (a_out_data !== 64'h40400000_00000000) begin n_err++; $display("FAIL flush_data: got %h want 4040000000000000", a_out_data); end
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0);
    cycle_a(1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_idx0: got valid %b ready %b want 0/1", a_out_valid, a_in_ready); end
    cycle_a(1'b1, 32'h1111_1111, 1'b0, 1'b1);
    n_cmp++; if (a_out_count !== 2'd1 || a_out_data !== 64'h11111111_00000000) begin n_err++; $display("FAIL flush_with_accept: got %0d/%h want 1/1111111100000000", a_out_count, a_out_data); end
    cycle_a(1'b0, 32'h0, 1'b0, 1'b1);
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_count !== 2'd1) begin n_err++; $display("FAIL flush_in_hold: got %b/%0d want 1/1", a_out_valid, a_out_count); end
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0);
`else
    cycle_a(1'b1, 32'h4040_0000, 1'b1, 1'b0);
    cycle_a(1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (a_out_valid !== 1'b0 || a_out_data !== 64'h40400000_00000000) begin n_err++; $display("FAIL flush_ignored: got %b/%h want 0/4040000000000000", a_out_valid, a_out_data); end
    cycle_a(1'b1, 32'h4080_0000, 1'b1, 1'b1);
    n_cmp++; if (a_out_count !== 2'd2 || a_out_data !== 64'h40400000_40800000) begin n_err++; $display("FAIL flush_full: got %0d/%h want 2/4040000040800000", a_out_count, a_out_data); end
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic         v, o, f;
    logic [W-1:0] d;
    int           exp_cnt;
    for (int k = 0; k < 300; k++) begin
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 7) == 0);
      d = $urandom();
      cycle_a(v, d, o, f);
      exp_cnt = m_hold ? m_cnt : 0;
      n_cmp++; if (a_in_ready !== !m_hold || a_out_valid !== m_hold) begin n_err++; $display("FAIL rand_flags@%0d: got ready %b valid %b want %b/%b", k, a_in_ready, a_out_valid, !m_hold, m_hold); end
      n_cmp++; if (a_out_data !== model_vec()) begin n_err++; $display("FAIL rand_data@%0d: got %h want %h", k, a_out_data, model_vec()); end
      n_cmp++; if (a_out_count !== 2'(exp_cnt)) begin n_err++; $display("FAIL rand_count@%0d: got %0d want %0d", k, a_out_count, exp_cnt); end
    end
    cycle_a(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int              next_word = 1;
    int              seen = 0;
    int              valid_cyc[2];
    logic            acc;
    logic [NB*W-1:0] exp_v;
    b_out_ready = 1'b1;
    for (int c = 0; c < 60 && seen < 2; c++) begin
      if (b_out_valid === 1'b1) begin
        exp_v = '0;
        for (int s = 0; s < NB; s++) exp_v[(NB-s)*W-1 -: W] = 32'(seen * NB + s + 1);
        n_cmp++; if (b_out_data !== exp_v || b_out_count !== 3'd4) begin n_err++; $display("FAIL b2b_vec%0d: got %h/%0d want %h/4", seen, b_out_data, b_out_count, exp_v); end
        valid_cyc[seen] = c;
        seen++;
      end
      b_in_valid = (next_word <= 8);
      b_in_data  = 32'(next_word);
      acc = b_in_valid && b_in_ready;
      @(posedge clk);
      if (acc) next_word++;
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    n_cmp++; if (seen != 2) begin n_err++; $display("FAIL b2b_timeout: got %0d vectors want 2", seen); end
    else begin
      n_cmp++; if (valid_cyc[0] != 4) begin n_err++; $display("FAIL b2b_latency: got cycle %0d want 4", valid_cyc[0]); end
      n_cmp++; if (valid_cyc[1] - valid_cyc[0] != 5) begin n_err++; $display("FAIL b2b_period: got %0d want 5", valid_cyc[1] - valid_cyc[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_flush();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vector_packer.md
VECTOR_PACKER -- requirements
Module: vector_packer

Interface
REQ-001 Parameter WIDTH, default 32: bits per word (one IEEE-754 single by default).
REQ-002 Parameter NUM_WORDS, default 2: words per packed vector; legal range 1..64.
REQ-003 clk  input  1  the block's only clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WIDTH  incoming word.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  the block accepts a word this cycle.
REQ-008 out_data  output  NUM_WORDS*WIDTH  packed vector; slot 0 is in bits [NUM_WORDS*WIDTH-1 -: WIDTH], and slot NUM_WORDS-1 is in bits [WIDTH-1:0].
REQ-009 out_valid  output  1  out_data holds a complete vector.
REQ-010 out_ready  input  1  the consumer takes the vector this cycle.
REQ-011 out_count  output  $clog2(NUM_WORDS+1)  number of valid slots in the vector being presented.
REQ-012 flush  input  1  request to emit a partial vector (functional only with the macro in REQ-027).

Function
REQ-013 The block shall serialise-to-parallel: successive accepted words fill slots 0,1,..,NUM_WORDS-1 in order.
REQ-014 The block shall have two states: FILL and HOLD.
REQ-015 In FILL, in_ready shall be 1 and out_valid shall be 0; a word is accepted when in_valid&&in_ready at a rising edge.
REQ-016 Accepted word shall be written to slot idx, where idx is a counter 0..NUM_WORDS-1 that increments on each accept.
REQ-017 Accept with idx==NUM_WORDS-1: next state HOLD, idx returns to 0, out_count becomes NUM_WORDS.
REQ-018 Latency: out_valid shall rise the cycle after the last word of the vector is accepted.
REQ-019 In HOLD, in_ready shall be 0, out_valid shall be 1, and out_data/out_count shall be stable until taken.
REQ-020 In HOLD, when out_ready is 1 at a rising edge, the block shall return to FILL and clear all slots to 0.
REQ-021 in_valid asserted while in HOLD shall be ignored (no write, no counter change); the producer holds the word.
REQ-022 Throughput: one vector per NUM_WORDS+1 cycles at best; no accept in the same cycle as a take.
REQ-023 Unwritten slots shall read 0; out_data in FILL shall reflect the partial contents but is not qualified.
REQ-024 NUM_WORDS==1: every accept shall move the block to HOLD.

Reset
REQ-025 On rst: state=FILL, idx=0, all slots=0, out_count=0, out_valid=0, in_ready=1 (after release).
REQ-026 Reset asserted mid-fill or in HOLD shall discard the partial or held vector immediately and shall emit no output.

Configuration
REQ-027 With VECTOR_PACKER_FLUSH_EN defined: flush=1 in FILL with idx>0 shall move the block to HOLD with out_count=idx; remaining slots stay 0.
REQ-028 With VECTOR_PACKER_FLUSH_EN defined: if flush coincides with an accept, the word shall be stored first and out_count=idx+1.
REQ-029 With VECTOR_PACKER_FLUSH_EN defined: flush with idx==0 and no accept, or flush in HOLD, shall have no effect.
REQ-030 Without VECTOR_PACKER_FLUSH_EN: flush shall be ignored, and out_count shall always be NUM_WORDS when out_valid=1.

Structure
REQ-031 The shared package fp_pkg shall hold FP_WIDTH=32 and the packer state enum {FILL, HOLD}.
REQ-032 The design shall be a single module with no sub-module; the slot register file is an array indexed by idx.

Verification (WIDTH=32, NUM_WORDS=2 unless noted)
REQ-033 Feed 0x3F800000 then 0x40000000, out_ready=1 -> out_valid one cycle after the 2nd accept, out_data=0x3F800000_40000000, out_count=2.
REQ-034 Same stimulus, out_ready=0 for 3 cycles -> out_data stable, in_ready=0 throughout, in_valid with 0xDEADBEEF is not stored; take on cycle 4, then in_ready=1.
REQ-035 Accept 0x12345678, assert rst for 1 cycle, then feed 0xAAAAAAAA, 0xBBBBBBBB -> vector 0xAAAAAAAA_BBBBBBBB; no spurious out_valid.
REQ-036 With VECTOR_PACKER_FLUSH_EN, accept 0x40400000 then flush -> out_data=0x40400000_00000000, out_count=1; flush at idx=0 -> nothing.
REQ-037 NUM_WORDS=4, 8 back-to-back words 1..8, out_ready=1 -> vectors 0x1_2_3_4 then 0x5_6_7_8 (32-bit slots), with 5 cycles per vector.
